// File: rtl/cpu_types_pkg.sv
// Basic datapath types shared by every pipeline stage.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;
endpackage

// File: rtl/data_path_muxs_pkg.sv
// Select encodings for the datapath muxes driven by the decoder.
package data_path_muxs_pkg;
  typedef enum logic [1:0] {
    REG_DEST_RT  = 2'd0,
    REG_DEST_RD  = 2'd1,
    REG_DEST_R31 = 2'd2
  } reg_dest_mux_selection;

  typedef enum logic [1:0] {
    MEM_TO_REG_ALU = 2'd0,
    MEM_TO_REG_MEM = 2'd1,
    MEM_TO_REG_NPC = 2'd2
  } mem_to_reg_mux_selection;
endpackage

// File: rtl/mem_stage_pkg.sv
// Memory-stage local types: access FSM states and the MEM/WB payload.
package mem_stage_pkg;
  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_DONE   = 2'd2
  } mem_state_t;

  localparam regbits_t R31 = 5'd31;

  typedef struct packed {
    logic     wen;
    regbits_t wsel;
    word_t    wdat;
    logic     halt;
  } mem_wb_t;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; freezes permanently once a halt has been latched.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic    CLK,
  input  logic    RST,
  input  logic    enable,
  input  logic    flush,
  input  mem_wb_t wb_in,
  output mem_wb_t wb_out
);

  mem_wb_t wb_q, wb_d;

  always_comb begin
    wb_d = wb_q;
    if (enable && !wb_q.halt)
      wb_d = flush ? '0 : wb_in;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) wb_q <= '0;
    else     wb_q <= wb_d;
  end

  assign wb_out = wb_q;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: holds the D-cache request until dhit, buffers load data across
// pipeline freezes so an access is never repeated, and selects write-back.
module mem_stage
  import cpu_types_pkg::*;
  import data_path_muxs_pkg::*;
  import mem_stage_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WEN_EX_MEM,
  input  logic                    dREN_EX_MEM,
  input  logic                    dWEN_EX_MEM,
  input  logic                    halt_EX_MEM,
  input  reg_dest_mux_selection   reg_dest_EX_MEM,
  input  mem_to_reg_mux_selection mem_to_reg_EX_MEM,
  input  regbits_t                Rt_EX_MEM,
  input  regbits_t                Rd_EX_MEM,
  input  word_t                   result_EX_MEM,
  input  word_t                   dmemaddr_EX_MEM,
  input  word_t                   dmemstore_EX_MEM,
  input  word_t                   next_imemaddr_EX_MEM,
  input  logic                    dhit,
  input  word_t                   dmemload,
  input  logic                    enable_MEM_WB,
  input  logic                    flush_MEM_WB,
  output logic                    dmemREN,
  output logic                    dmemWEN,
  output word_t                   dmemaddr,
  output word_t                   dmemstore,
  output logic                    stall_MEM,
  output logic                    WEN_MEM_WB,
  output regbits_t                wsel_MEM_WB,
  output word_t                   wdat_MEM_WB,
  output logic                    halt_MEM_WB,
  output logic [CNT_W-1:0]        mem_stall_cnt
);

  mem_state_t       state_q, state_d;
  word_t            load_buf_q, load_buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_op, request, advance;
  word_t            load_val;
  mem_wb_t          wb_in, wb_out;

  // Request is gated by RST so it drops asynchronously even while EX/MEM
  // still presents a memory op.
  always_comb begin
    mem_op  = (dREN_EX_MEM | dWEN_EX_MEM) & ~halt_MEM_WB;
    request = (((state_q == MEM_IDLE) & mem_op) | (state_q == MEM_ACCESS))
              & ~halt_MEM_WB & ~RST;
  end

  assign dmemREN   = request & dREN_EX_MEM;
  assign dmemWEN   = request & dWEN_EX_MEM & ~dREN_EX_MEM;
  assign dmemaddr  = dmemaddr_EX_MEM;
  assign dmemstore = dmemstore_EX_MEM;
  assign stall_MEM = request & ~dhit;
  assign advance   = enable_MEM_WB & ~stall_MEM;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MEM_IDLE: begin
        if (request)
          state_d = !dhit ? MEM_ACCESS : (advance ? MEM_IDLE : MEM_DONE);
      end
      MEM_ACCESS: begin
        if (!request)  state_d = MEM_IDLE;
        else if (dhit) state_d = advance ? MEM_IDLE : MEM_DONE;
      end
      MEM_DONE: begin
        if (enable_MEM_WB) state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_comb begin
    load_buf_d = load_buf_q;
    if (request && dhit && !advance) load_buf_d = dmemload;
    load_val = (state_q == MEM_DONE) ? load_buf_q : dmemload;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_MEM && !(&cnt_q)) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_comb begin
    wb_in      = '0;
    wb_in.wen  = WEN_EX_MEM;
    wb_in.halt = halt_EX_MEM;
    unique case (reg_dest_EX_MEM)
      REG_DEST_RT:  wb_in.wsel = Rt_EX_MEM;
      REG_DEST_RD:  wb_in.wsel = Rd_EX_MEM;
      REG_DEST_R31: wb_in.wsel = R31;
      default:      wb_in.wsel = Rt_EX_MEM;
    endcase
    unique case (mem_to_reg_EX_MEM)
      MEM_TO_REG_ALU: wb_in.wdat = result_EX_MEM;
      MEM_TO_REG_MEM: wb_in.wdat = load_val;
      MEM_TO_REG_NPC: wb_in.wdat = next_imemaddr_EX_MEM;
      default:        wb_in.wdat = result_EX_MEM;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= MEM_IDLE;
      load_buf_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      load_buf_q <= load_buf_d;
      cnt_q      <= cnt_d;
    end
  end

  mem_wb_reg u_mem_wb (
    .CLK    (CLK),
    .RST    (RST),
    .enable (advance),
    .flush  (flush_MEM_WB),
    .wb_in  (wb_in),
    .wb_out (wb_out)
  );

  assign WEN_MEM_WB    = wb_out.wen;
  assign wsel_MEM_WB   = wb_out.wsel;
  assign wdat_MEM_WB   = wb_out.wdat;
  assign halt_MEM_WB   = wb_out.halt;
  assign mem_stall_cnt = cnt_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage pipeline. It consumes the EX/MEM register outputs and issues data-cache requests, holding each request until `dhit`. It buffers completed load data while the pipeline is frozen, so no access is ever re-issued. It selects the write-back value and destination register and owns the MEM/WB pipeline register that feeds the register file.

## Interface
Parameters:
- `CNT_W`, 32: width of the memory-stall performance counter.

Ports (reset is asynchronous, active-high; all types come from `cpu_types_pkg` and `data_path_muxs_pkg`):
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `WEN_EX_MEM, dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM`  in  1 each  control bits from EX/MEM.
- `reg_dest_EX_MEM`  in  reg_dest_mux_selection  destination select (RT / RD / R31).
- `mem_to_reg_EX_MEM`  in  mem_to_reg_mux_selection  write-back source (ALU / MEM / NPC).
- `Rt_EX_MEM, Rd_EX_MEM`  in  regbits_t  register fields.
- `result_EX_MEM, dmemaddr_EX_MEM, dmemstore_EX_MEM, next_imemaddr_EX_MEM`  in  word_t  ALU result, memory address, store data, PC+4.
- `dhit`  in  1  data cache access complete.
- `dmemload`  in  word_t  load data, valid while `dhit` is high.
- `enable_MEM_WB, flush_MEM_WB`  in  1  hazard-unit advance and bubble controls.
- `dmemREN, dmemWEN`  out  1  data cache read and write requests.
- `dmemaddr, dmemstore`  out  word_t  request address and store data.
- `stall_MEM`  out  1  memory stage busy; the hazard unit freezes PC, IF/ID, ID/EX and EX/MEM.
- `WEN_MEM_WB`  out  1  register-file write enable.
- `wsel_MEM_WB`  out  regbits_t  register-file write select.
- `wdat_MEM_WB`  out  word_t  register-file write data.
- `halt_MEM_WB`  out  1  sticky halt.
- `mem_stall_cnt`  out  CNT_W  saturating count of stall cycles.

## Operation
- A memory op is present when `dREN_EX_MEM | dWEN_EX_MEM` is high and `halt_MEM_WB` is low. If both enables are high, the op is a load and no store is issued.
- FSM states: `MEM_IDLE`, `MEM_ACCESS`, `MEM_DONE`.
  - IDLE, memory op present: drive the request combinationally. With `dhit`, go to IDLE if the stage advances, otherwise to DONE. Without `dhit`, go to ACCESS.
  - ACCESS: keep the request. With `dhit`, go to IDLE if the stage advances, otherwise to DONE.
  - DONE: no request. On `enable_MEM_WB`, go to IDLE.
- Request outputs:
  - `dmemREN`/`dmemWEN` are asserted only in IDLE (op present) and in ACCESS.
  - `dmemaddr = dmemaddr_EX_MEM` and `dmemstore = dmemstore_EX_MEM` at all times.
- `stall_MEM = request & ~dhit`.
- "Advance" means `enable_MEM_WB & ~stall_MEM`.
- On `dhit` without advance, `dmemload` is captured into `load_buf`. In DONE, the load value comes from `load_buf`.
- Write-back data selection:
  - ALU → `result_EX_MEM`.
  - MEM → `dmemload` (or `load_buf` in DONE).
  - NPC → `next_imemaddr_EX_MEM`.
- Write select: RT → `Rt_EX_MEM`, RD → `Rd_EX_MEM`, R31 → 5'd31.
- MEM/WB register update on an edge:
  - On advance, it captures `WEN`, `wsel`, `wdat` and `halt`.
  - If `flush_MEM_WB` is also high, it loads zeros instead.
  - The flush takes effect only on an advancing edge.
- `halt_MEM_WB` is sticky once set. After that, MEM/WB holds its contents and no requests are issued.
- `mem_stall_cnt` increments on every edge where `stall_MEM` is high and saturates at all-ones.

## Timing
- Reset values:
  - State is IDLE.
  - All MEM/WB outputs, `load_buf` and `mem_stall_cnt` are 0.
  - `dmemREN`/`dmemWEN` go to 0 immediately, including mid-ACCESS.
- Latency:
  - A cache hit in the first cycle gives zero stall cycles; MEM/WB is valid one edge after the op enters MEM.
  - An N-cycle miss gives N stall cycles.
- A non-memory instruction never stalls and always advances when `enable_MEM_WB` is high.
- A store completes exactly once: in DONE, `dmemWEN` stays low even if the pipeline is frozen for many cycles.
- `dhit` while no request is outstanding is ignored.

## Structure
- `mem_stage_pkg` holds `mem_state_t` (`MEM_IDLE`, `MEM_ACCESS`, `MEM_DONE`) and `R31 = 5'd31`. Mux enums stay in `data_path_muxs_pkg`.
- Sub-module `mem_wb_reg` contains the MEM/WB flops: `enable`, `flush`, sticky halt, and the `WEN`/`wsel`/`wdat` fields. The FSM, muxes and counter live in `mem_stage`.

## Test plan
- LW with `dhit` in the first cycle, ALU→MEM, `dmemload`=0xDEADBEEF, Rt=5 → no stall. Next edge: `WEN_MEM_WB`=1, `wsel`=5, `wdat`=0xDEADBEEF.
- SW with `dhit` delayed 3 cycles → `stall_MEM` high for 3 cycles, `dmemWEN` high for 4 cycles, `mem_stall_cnt`=3.
- LW hit while `enable_MEM_WB`=0 for 4 cycles, then 1:
  - State goes to DONE and `dmemREN` stays low for those cycles.
  - `dmemload` changes to 0x1 during the freeze.
  - `wdat_MEM_WB` still equals the original hit data 0xCAFE0000.
- JAL with R31/NPC selects, `next_imemaddr`=0x44 → `wsel`=31, `wdat`=0x44. Same with `flush_MEM_WB`=1 → all MEM/WB outputs 0.
- `halt_EX_MEM`=1 advances → `halt_MEM_WB`=1 and stays 1. A following SW issues no `dmemWEN`.
- `RST` pulsed mid-ACCESS (no `dhit`) → `dmemREN` falls without waiting for a clock edge. State is IDLE, all outputs and the counter are 0.
